// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and defaults for the BTB update controller: FSM encoding,
// parameter defaults and the queued update record.
package btb_update_ctrl_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned SETS_DEF  = 32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } upd_entry_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Circular update queue: DEPTH entries, power-of-two pointers that wrap
// naturally, occupancy counter one bit wider than the pointers.
module btb_upd_fifo
  import btb_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  upd_entry_t                 entry_i,
  input  logic                       pop_i,
  output upd_entry_t                 entry_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  upd_entry_t    mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign entry_o = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; a clear overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: only slots covered by occupancy are read.
  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: sweeps every BTB set clear after reset/flush, then
// drains queued taken-branch updates onto a one-cycle update strobe.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned SETS  = SETS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid_i,
  input  logic [31:0]             upd_pc_i,
  input  logic [31:0]             upd_target_i,
  input  logic                    upd_taken_i,
  output logic                    upd_ready_o,
  input  logic                    flush_i,
  output logic                    btb_init_o,
  output logic [$clog2(SETS)-1:0] btb_init_set_o,
  output logic                    btb_upd_o,
  output logic [31:0]             btb_upd_pc_o,
  output logic [31:0]             btb_upd_target_o,
  output logic                    lookup_block_o,
  output logic [7:0]              drop_cnt_o
);

  localparam int unsigned SW = $clog2(SETS);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [SW-1:0] set_q, set_d;
  logic          upd_q, upd_d;
  logic [31:0]   upd_pc_q, upd_pc_d;
  logic [31:0]   upd_tgt_q, upd_tgt_d;
  logic [7:0]    drop_q, drop_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          accept;
  logic          pop;
  logic          lost;
  upd_entry_t    push_entry;
  upd_entry_t    head_entry;

  assign push_entry = '{pc: upd_pc_i, target: upd_target_i};
  assign accept     = upd_valid_i & ~fifo_full & upd_taken_i & ~flush_i;
  assign pop        = (state_q == ST_RUN) & ~fifo_empty & ~flush_i;
  assign lost       = upd_valid_i & upd_taken_i & ~flush_i & (fifo_count == CW'(DEPTH));

  btb_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush_i),
    .push_i  (accept),
    .entry_i (push_entry),
    .pop_i   (pop),
    .entry_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sweep/run sequencing; flush always restarts the sweep from set 0.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    if (flush_i) begin
      state_d = ST_INIT;
      set_d   = {SW{1'b0}};
    end else begin
      case (state_q)
        ST_INIT: begin
          if (set_q == SW'(SETS - 1)) begin
            state_d = ST_RUN;
            set_d   = {SW{1'b0}};
          end else begin
            state_d = ST_INIT;
            set_d   = set_q + SW'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
          set_d   = {SW{1'b0}};
        end
        default: begin
          state_d = ST_INIT;
          set_d   = {SW{1'b0}};
        end
      endcase
    end
  end

  // Update strobe, held update payload and saturating drop counter.
  always_comb begin
    upd_d     = pop;
    upd_pc_d  = upd_pc_q;
    upd_tgt_d = upd_tgt_q;
    drop_d    = drop_q;
    if (pop) begin
      upd_pc_d  = head_entry.pc;
      upd_tgt_d = head_entry.target;
    end else begin
      upd_pc_d  = upd_pc_q;
      upd_tgt_d = upd_tgt_q;
    end
    if (lost && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      set_q     <= {SW{1'b0}};
      upd_q     <= 1'b0;
      upd_pc_q  <= 32'h0000_0000;
      upd_tgt_q <= 32'h0000_0000;
      drop_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      upd_q     <= upd_d;
      upd_pc_q  <= upd_pc_d;
      upd_tgt_q <= upd_tgt_d;
      drop_q    <= drop_d;
    end
  end

  assign upd_ready_o      = ~fifo_full;
  assign btb_init_o       = (state_q == ST_INIT);
  assign lookup_block_o   = (state_q == ST_INIT);
  assign btb_init_set_o   = set_q;
  assign btb_upd_o        = upd_q;
  assign btb_upd_pc_o     = upd_pc_q;
  assign btb_upd_target_o = upd_tgt_q;
  assign drop_cnt_o       = drop_q;

endmodule
